// File: rtl/stereo_pkg.sv
// Shared frame-buffer geometry and packer state encoding for the stereo disparity datapath.
// The matcher reads the same constants, so the address layout stays consistent between the two.
package stereo_pkg;
    localparam int PIX_W         = 8;
    localparam int BLOCK_SIZE    = 6;
    localparam int IMG_WIDTH     = 240;
    localparam int IMG_HEIGHT    = 320;
    localparam int WORDS_PER_ROW = IMG_WIDTH / BLOCK_SIZE;
    localparam int FB_ADDR_W     = $clog2(IMG_HEIGHT * WORDS_PER_ROW);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        PACK     = 2'd1,
        HANDOFF  = 2'd2,
        BUSY     = 2'd3
    } packer_state_t;
endpackage

// File: rtl/pixel_word_lanes.sv
// Collects BLOCK_SIZE pixels into one word; word_done is combinational on the final lane.
// Latency 0 (word valid with the last pixel); no backpressure, shifts whenever shift_vld is high.
module pixel_word_lanes #(
    parameter int BLOCK_SIZE = 6,
    parameter int PIX_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        shift_vld,
    input  logic                        restart,
    input  logic [PIX_W-1:0]            pixel_dat,
    output logic                        word_done,
    output logic [BLOCK_SIZE*PIX_W-1:0] word_dat
);
    localparam int LW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam logic [LW-1:0] LANE_LAST = LW'(BLOCK_SIZE - 1);

    // The last lane is never stored: it is taken straight from pixel_dat.
    logic [BLOCK_SIZE-2:0][PIX_W-1:0] lanes;
    logic [LW-1:0]                    lane_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes    <= '0;
            lane_cnt <= '0;
        end else if (shift_vld) begin
            if (restart) begin
                lanes[0] <= pixel_dat;
                lane_cnt <= LW'(1);
            end else if (lane_cnt == LANE_LAST) begin
                lane_cnt <= '0;
            end else begin
                lanes[lane_cnt] <= pixel_dat;
                lane_cnt        <= lane_cnt + LW'(1);
            end
        end
    end

    assign word_done = shift_vld && !restart && (lane_cnt == LANE_LAST);
    assign word_dat  = {pixel_dat, lanes};
endmodule

// File: rtl/frame_word_packer.sv
// Packs one camera's raster pixel stream into BLOCK_SIZE-pixel words for the frame-buffer BRAM.
// Write 1 cycle after the block's last pixel; no backpressure (BUSY drops frames); STEREO_DROP_COUNT_EN adds drop_count_out.
module frame_word_packer
    import stereo_pkg::packer_state_t;
    import stereo_pkg::WAIT_SOF;
    import stereo_pkg::PACK;
    import stereo_pkg::HANDOFF;
    import stereo_pkg::BUSY;
#(
    parameter int IMG_WIDTH  = stereo_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT = stereo_pkg::IMG_HEIGHT,
    parameter int BLOCK_SIZE = stereo_pkg::BLOCK_SIZE,
    parameter int PIX_W      = stereo_pkg::PIX_W
) (
    input  logic                                              clk_in,
    input  logic                                              rst_n_in,
    input  logic                                              pixel_valid_in,
    input  logic [PIX_W-1:0]                                  pixel_in,
    input  logic                                              sof_in,
    input  logic                                              core_done_in,
    output logic                                              wr_en_out,
    output logic [$clog2(IMG_HEIGHT*IMG_WIDTH/BLOCK_SIZE)-1:0] wr_addr_out,
    output logic [BLOCK_SIZE*PIX_W-1:0]                       wr_data_out,
    output logic                                              writing_image_out,
    output logic                                              frame_ready_out
`ifdef STEREO_DROP_COUNT_EN
    ,
    output logic [7:0]                                        drop_count_out
`endif
);
    localparam int ADDR_W = $clog2(IMG_HEIGHT * IMG_WIDTH / BLOCK_SIZE);
    localparam int XW     = $clog2(IMG_WIDTH);
    localparam int YW     = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0]     X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0]     Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] WPR    = ADDR_W'(IMG_WIDTH / BLOCK_SIZE);

    packer_state_t state, state_nxt;

    logic [XW-1:0]              x;
    logic [YW-1:0]              y;
    logic [ADDR_W-1:0]          word_idx;
    logic [ADDR_W-1:0]          row_base;
    logic                       final_wr;
    logic                       word_done;
    logic [BLOCK_SIZE*PIX_W-1:0] word_dat;

    logic sof_vld, pack_open, start, pix_acc, last_pix;

    // The final-write cycle still counts as PACK but no longer accepts pixels.
    assign sof_vld   = pixel_valid_in && sof_in;
    assign pack_open = (state == PACK) && !final_wr;
    assign start     = sof_vld && ((state == WAIT_SOF) || pack_open ||
                                   ((state == BUSY) && core_done_in));
    assign pix_acc   = pixel_valid_in && !sof_in && pack_open;
    assign last_pix  = pix_acc && (x == X_LAST) && (y == Y_LAST);

    pixel_word_lanes #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .PIX_W      (PIX_W)
    ) u_lanes (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .shift_vld (start || pix_acc),
        .restart   (start),
        .pixel_dat (pixel_in),
        .word_done (word_done),
        .word_dat  (word_dat)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= WAIT_SOF;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_SOF: if (start) state_nxt = PACK;
            PACK:     if (final_wr) state_nxt = HANDOFF;
            HANDOFF:  state_nxt = BUSY;
            BUSY: begin
                if (start)             state_nxt = PACK;
                else if (core_done_in) state_nxt = WAIT_SOF;
            end
            default:  state_nxt = WAIT_SOF;
        endcase
    end

    // Raster position; word_idx rides alongside x so the address needs only an adder.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x        <= '0;
            y        <= '0;
            word_idx <= '0;
            row_base <= '0;
        end else if (start) begin
            x        <= XW'(1);
            y        <= '0;
            word_idx <= '0;
            row_base <= '0;
        end else if (pix_acc) begin
            if (x == X_LAST) begin
                x        <= '0;
                y        <= y + YW'(1);
                word_idx <= '0;
                row_base <= row_base + WPR;
            end else begin
                x <= x + XW'(1);
                if (word_done) word_idx <= word_idx + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_en_out   <= 1'b0;
            wr_addr_out <= '0;
            wr_data_out <= '0;
            final_wr    <= 1'b0;
        end else begin
            wr_en_out <= word_done;
            final_wr  <= last_pix;
            if (word_done) begin
                wr_addr_out <= row_base + word_idx;
                wr_data_out <= word_dat;
            end
        end
    end

    assign writing_image_out = (state == PACK);
    assign frame_ready_out   = (state == HANDOFF);

`ifdef STEREO_DROP_COUNT_EN
    logic       drop;
    logic [7:0] drop_cnt;

    // An SOF we cannot take (core still busy) or one that aborts a frame in flight.
    assign drop = sof_vld && (pack_open || (state == HANDOFF) ||
                              ((state == BUSY) && !core_done_in));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)                     drop_cnt <= 8'd0;
        else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end

    assign drop_count_out = drop_cnt;
`endif
endmodule

// File: tb/tb_frame_word_packer.sv
// Directed bench for frame_word_packer on a reduced 12x4 frame (8 words, 2 per row).
// A negedge observer logs BRAM writes and frame_ready pulses; expected words come from exp_word().
module tb_frame_word_packer;
    localparam int W = 12, H = 4, B = 6, P = 8, WORDS = 8, AW = 3;

    logic clk = 1'b0, rst_n = 1'b0, pv = 1'b0, sof = 1'b0, cd = 1'b0;
    logic [7:0]    pix = 8'd0;
    logic          wr_en, writing, fr;
    logic [AW-1:0] wr_addr;
    logic [47:0]   wr_data;
`ifdef STEREO_DROP_COUNT_EN
    logic [7:0]    drop;
`endif

    int checks = 0, errors = 0, wr_count = 0, fr_count = 0;
    int base_w, base_f;
    logic [47:0] mem [WORDS];

    always #5 clk = ~clk;

    frame_word_packer #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .BLOCK_SIZE(B), .PIX_W(P)
    ) dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .pixel_valid_in    (pv),
        .pixel_in          (pix),
        .sof_in            (sof),
        .core_done_in      (cd),
        .wr_en_out         (wr_en),
        .wr_addr_out       (wr_addr),
        .wr_data_out       (wr_data),
        .writing_image_out (writing),
        .frame_ready_out   (fr)
`ifdef STEREO_DROP_COUNT_EN
        ,
        .drop_count_out    (drop)
`endif
    );

    always @(negedge clk) begin
        if (wr_en) begin
            wr_count++;
            mem[wr_addr] = wr_data;
        end
        if (fr) fr_count++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic c, input logic [7:0] p);
        pv = v; sof = s; cd = c; pix = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    function automatic logic [47:0] exp_word(input int seed, input int a);
        logic [47:0] r;
        int yy, ww;
        yy = a / 2;
        ww = a % 2;
        r = '0;
        for (int k = 0; k < B; k++) r[8*k +: 8] = 8'(seed + yy*W + ww*B + k);
        return r;
    endfunction

    task automatic send_frame(input int seed, input bit gaps, input logic cd0);
        for (int i = 0; i < W*H; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'b0, 8'd0);
            drive(1'b1, i == 0, cd0 && (i == 0), 8'(seed + i));
        end
    endtask

    task automatic check_mem(input string tag, input int seed);
        for (int a = 0; a < WORDS; a++)
            check($sformatf("%s[%0d]", tag, a), mem[a], exp_word(seed, a));
    endtask

    initial begin
        // Reset state
        idle(2);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_writing", writing, 0);
        check("rst_frame_ready", fr, 0);
`ifdef STEREO_DROP_COUNT_EN
        check("rst_drop", drop, 0);
`endif
        rst_n = 1'b1;
        idle(1);

        // Valid pixels without SOF are ignored
        base_w = wr_count;
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, 8'(i));
        idle(1);
        check("nosof_writing", writing, 0);
        check("nosof_writes", wr_count - base_w, 0);

        // Gap-free ramp frame, pixel i = i+1
        base_w = wr_count; base_f = fr_count;
        for (int i = 0; i < W*H; i++) begin
            drive(1'b1, i == 0, 1'b0, 8'(i + 1));
            if (i == 0) check("sof_writing_rise", writing, 1);
            if (i == 4) check("no_early_write", wr_en, 0);
            if (i == 5) begin
                check("w0_en", wr_en, 1);
                check("w0_addr", wr_addr, 0);
                check("w0_data", wr_data, 48'h060504030201);
            end
            if (i == 6) check("w0_single_cycle", wr_en, 0);
            if (i == 17) begin
                check("row1_w0_en", wr_en, 1);
                check("row1_w0_addr", wr_addr, 2);
            end
            if (i == W*H-1) begin
                check("last_en", wr_en, 1);
                check("last_addr", wr_addr, WORDS - 1);
                check("last_writing", writing, 1);
                check("last_no_ready", fr, 0);
            end
        end
        idle(1);
        check("handoff_ready", fr, 1);
        check("handoff_writing", writing, 0);
        check("handoff_no_write", wr_en, 0);
        idle(1);
        check("ready_one_cycle", fr, 0);
        check("f1_writes", wr_count - base_w, WORDS);
        check("f1_ready", fr_count - base_f, 1);
        check_mem("f1_mem", 1);

        // SOF while BUSY: whole frame dropped
        base_w = wr_count; base_f = fr_count;
        send_frame(60, 1'b0, 1'b0);
        check("busy_writing", writing, 0);
        drive(1'b0, 1'b0, 1'b1, 8'd0);
        idle(2);
        check("busy_drop_writes", wr_count - base_w, 0);
        check("busy_drop_ready", fr_count - base_f, 0);
`ifdef STEREO_DROP_COUNT_EN
        check("busy_drop_count", drop, 1);
`endif
        send_frame(101, 1'b0, 1'b0);
        idle(2);
        check("f2_writes", wr_count - base_w, WORDS);
        check("f2_ready", fr_count - base_f, 1);
        check_mem("f2_mem", 101);

        // SOF mid-frame aborts and restarts at (0,0)
        drive(1'b0, 1'b0, 1'b1, 8'd0);
        idle(1);
        base_w = wr_count; base_f = fr_count;
        for (int i = 0; i < 20; i++) drive(1'b1, i == 0, 1'b0, 8'(200 + i));
        check("abort_pre_writing", writing, 1);
        for (int i = 0; i < W*H; i++) begin
            drive(1'b1, i == 0, 1'b0, 8'(30 + i));
            if (i == 0) check("abort_writing_held", writing, 1);
            if (i == 4) check("abort_no_early", wr_en, 0);
            if (i == 5) begin
                check("abort_w0_addr", wr_addr, 0);
                check("abort_w0_data", wr_data, exp_word(30, 0));
            end
        end
        idle(2);
        check("abort_writes", wr_count - base_w, 3 + WORDS);
        check("abort_ready", fr_count - base_f, 1);
`ifdef STEREO_DROP_COUNT_EN
        check("abort_drop_count", drop, 2);
`endif
        check_mem("f3_mem", 30);

        // core_done coincident with SOF, random valid gaps
        base_w = wr_count; base_f = fr_count;
        send_frame(77, 1'b1, 1'b1);
        idle(2);
        check("coinc_writes", wr_count - base_w, WORDS);
        check("coinc_ready", fr_count - base_f, 1);
`ifdef STEREO_DROP_COUNT_EN
        check("coinc_drop_count", drop, 2);
`endif
        check_mem("f4_mem", 77);

        // Asynchronous reset mid-row
        drive(1'b0, 1'b0, 1'b1, 8'd0);
        idle(1);
        for (int i = 0; i < 6; i++) drive(1'b1, i == 0, 1'b0, 8'(5 + i));
        check("prerst_wr_en", wr_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_wr_en", wr_en, 0);
        check("arst_wr_addr", wr_addr, 0);
        check("arst_wr_data", wr_data, 0);
        check("arst_writing", writing, 0);
        check("arst_ready", fr, 0);
        idle(2);
        rst_n = 1'b1;
        base_w = wr_count; base_f = fr_count;
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 1'b0, 8'(i));
        idle(2);
        check("postrst_writes", wr_count - base_w, 0);
        check("postrst_writing", writing, 0);
        send_frame(9, 1'b0, 1'b0);
        idle(2);
        check("f5_writes", wr_count - base_w, WORDS);
        check("f5_ready", fr_count - base_f, 1);
        check_mem("f5_mem", 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_word_packer.md
# frame_word_packer

Upstream feeder for the stereo disparity core. It accepts one camera's 8-bit grayscale pixel stream in row-major order and packs each run of BLOCK_SIZE consecutive pixels into one 48-bit word. Each word is written to that camera's frame-buffer BRAM at the address layout the matcher reads, and frame completion is handed to the core. The top level instantiates two copies, one for left and one for right, and ANDs their frame_ready_out pulses to form new_frame_in.

## Interface
- IMG_WIDTH, 240: pixels per row (x); must be a multiple of BLOCK_SIZE
- IMG_HEIGHT, 320: rows per frame (y)
- BLOCK_SIZE, 6: pixels per packed word
- PIX_W, 8: bits per pixel
- clk_in  input  1  system clock (100 MHz domain)
- rst_n_in  input  1  asynchronous, active-low reset
- pixel_valid_in  input  1  pixel_in is valid this cycle
- pixel_in  input  PIX_W  grayscale pixel
- sof_in  input  1  start of frame; qualified by pixel_valid_in; marks pixel (0,0)
- core_done_in  input  1  one-cycle pulse from the core (new_frame_out) when the disparity frame is finished
- wr_en_out  output  1  frame-buffer write enable
- wr_addr_out  output  $clog2(IMG_HEIGHT*IMG_WIDTH/BLOCK_SIZE)  word address = y*WORDS_PER_ROW + word_idx
- wr_data_out  output  BLOCK_SIZE*PIX_W  packed word; pixel k of the block occupies bits [8k+7:8k]
- writing_image_out  output  1  high while this block owns the BRAM port
- frame_ready_out  output  1  one-cycle pulse when a full frame is stored
- drop_count_out  output  8  saturating count of rejected frames (only when STEREO_DROP_COUNT_EN is defined)

## Operation
- States:
  - WAIT_SOF: entered after reset.
  - PACK: active while a frame is being written.
  - HANDOFF: single cycle after the final write.
  - BUSY: waiting for the core to finish.
- WAIT_SOF:
  - Valid pixels without sof_in are ignored.
  - Valid+sof_in captures the pixel as lane 0 of (0,0) and moves to PACK.
- PACK:
  - Each valid pixel goes into lane `lane_cnt`. x, lane_cnt and word_idx advance; x wraps at IMG_WIDTH, which resets lane_cnt and word_idx and increments y.
  - On lane BLOCK_SIZE-1 the assembled word is registered and written.
  - After the write for (IMG_WIDTH-1, IMG_HEIGHT-1), go to HANDOFF.
- HANDOFF: pulse frame_ready_out, go to BUSY.
- BUSY:
  - Pixels are ignored.
  - sof_in arriving while in BUSY causes the whole incoming frame to be dropped, and drop_count increments once.
  - core_done_in moves the FSM to WAIT_SOF.
  - If core_done_in and valid+sof_in arrive in the same cycle, the SOF is accepted directly into PACK and nothing is dropped.
- sof_in during PACK: the partial frame is abandoned, counting restarts at (0,0) with this pixel, and drop_count increments. Already-written words are simply overwritten.
- Gaps in pixel_valid_in are allowed anywhere; counters hold.
- Lane shift register: unwritten lanes carry no meaning; a word is written only when complete.
- Arithmetic: the address is formed by a running row base (row_base += WORDS_PER_ROW on row wrap) plus word_idx. No multiplier is used.

## Timing
- Reset values: wr_en_out=0, wr_addr_out=0, wr_data_out=0, writing_image_out=0, frame_ready_out=0, drop_count=0, state=WAIT_SOF.
- Write latency: wr_en_out is high for exactly one cycle, one cycle after the 6th pixel of the block is accepted.
- writing_image_out:
  - Rises the cycle after the accepted SOF and stays high through the final write cycle.
  - Falls in the HANDOFF cycle, the same cycle frame_ready_out pulses.
  - An aborted frame keeps it high continuously.
- Throughput is one pixel per cycle sustained. A minimum frame takes IMG_WIDTH*IMG_HEIGHT + 2 cycles from SOF to frame_ready_out.
- Reset asserted mid-frame: all outputs are cleared immediately (asynchronously); the next frame is accepted only on a fresh SOF.

## Configuration
- STEREO_DROP_COUNT_EN defined:
  - The drop_count_out port and its 8-bit saturating counter exist.
  - The counter increments on each BUSY-rejected frame and each PACK abort, and sticks at 255.
- Undefined: the port and counter are absent; drop behaviour is otherwise identical.

## Structure
- stereo_pkg holds BLOCK_SIZE, IMG_WIDTH, IMG_HEIGHT, WORDS_PER_ROW (IMG_WIDTH/BLOCK_SIZE), the FB_ADDR_W constant, and the packer state enum. The matcher uses the same constants.
- One sub-module, pixel_word_lanes, contains the lane register file and lane counter. It exposes word_done and the packed word.

## Test plan
- Pixels 0x01..0x06 at x=0..5 of row 0 after SOF -> one write: addr 0, data 0x060504030201, one cycle after the 0x06 pixel.
- Full 240x320 ramp frame -> exactly 12800 writes. The row-1 first word goes to addr 40 and the last word to addr 12799. frame_ready_out pulses once, 2 cycles after the last pixel.
- Random pixel_valid_in gaps on a full frame -> the BRAM model matches the gap-free run, and no write occurs without 6 new pixels.
- A second SOF while in BUSY, then core_done_in -> no writes and no frame_ready_out for that frame; drop_count_out=1; the next SOF is packed normally.
- SOF re-asserted at pixel 1000 of a frame -> counting restarts, the next write is addr 0, and drop_count_out=1. Separately, core_done_in coincident with SOF -> frame accepted, drop_count_out unchanged.
- rst_n_in pulsed low mid-row -> all outputs 0 within the same cycle; pixels ignored until the next SOF.
